// File: rtl/mul_div_arbiter_if.sv
// Handshake bundle between two clients, the round-robin arbiter and the shared
// multiply/divide unit.
interface mul_div_arbiter_if #(
  parameter int unsigned LAT = 3
) ();
  localparam int unsigned CntW = $clog2(LAT + 1);

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [31:0]     req_a0;
  logic [31:0]     req_b0;
  logic [31:0]     req_a1;
  logic [31:0]     req_b1;
  logic [1:0]      req_sel;
  logic [31:0]     mdu_a;
  logic [31:0]     mdu_b;
  logic            mdu_sel;
  logic            mdu_en;
  logic [31:0]     mdu_r;
  logic [4:0]      mdu_flags;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [31:0]     rsp_r;
  logic [4:0]      rsp_flags;
  logic [CntW-1:0] inflight;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_sel, rsp_ready, mdu_r, mdu_flags,
    input  req_ready, mdu_a, mdu_b, mdu_sel, mdu_en, rsp_valid, rsp_r, rsp_flags, inflight
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_sel, rsp_ready, mdu_r, mdu_flags,
    output req_ready, mdu_a, mdu_b, mdu_sel, mdu_en, rsp_valid, rsp_r, rsp_flags, inflight
  );
endinterface

// File: rtl/mul_div_arbiter.sv
// Round-robin scheduler sharing one LAT-deep multiply/divide pipeline between two
// clients; a tag shift register routes each result back to its owner.
module mul_div_arbiter #(
  parameter int unsigned LAT = 3
) (
  input logic              i_clk,
  input logic              i_arst,
  mul_div_arbiter_if.slave bus
);
  localparam int unsigned CntW = $clog2(LAT + 1);

  logic [LAT-1:0]  r_vld;
  logic [LAT-1:0]  r_tag;
  logic            r_last_grant;
  logic [CntW-1:0] r_inflight;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic            r_sel;

  logic            w_tail_vld;
  logic            w_tail_tag;
  logic            w_en;
  logic            w_grant;
  logic            w_issue;
  logic            w_rsp_hs;
  logic [31:0]     w_a;
  logic [31:0]     w_b;
  logic            w_sel;

  always_comb begin
    w_tail_vld = r_vld[LAT-1];
    w_tail_tag = r_tag[LAT-1];
    // Freeze the whole unit while the oldest result's owner is not ready.
    w_en       = !(w_tail_vld && !bus.rsp_ready[w_tail_tag]);
    w_rsp_hs   = w_tail_vld && w_en;
    if (&bus.req_valid) begin
      w_grant = !r_last_grant;
    end else begin
      w_grant = bus.req_valid[1];
    end
    w_issue = w_en && bus.req_valid[w_grant];
    w_a     = w_grant ? bus.req_a1 : bus.req_a0;
    w_b     = w_grant ? bus.req_b1 : bus.req_b0;
    w_sel   = bus.req_sel[w_grant];
  end

  always_comb begin
    bus.req_ready = 2'b00;
    if (w_issue) begin
      bus.req_ready[w_grant] = 1'b1;
    end
    bus.mdu_a     = w_issue ? w_a : r_a;
    bus.mdu_b     = w_issue ? w_b : r_b;
    bus.mdu_sel   = w_issue ? w_sel : r_sel;
    bus.mdu_en    = w_en;
    bus.rsp_valid = {w_tail_vld && w_tail_tag, w_tail_vld && !w_tail_tag};
    bus.rsp_r     = bus.mdu_r;
    bus.rsp_flags = bus.mdu_flags;
    bus.inflight  = r_inflight;
  end

  // Bubbles shift in as invalid slots so the tracker stays aligned with the unit.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_vld <= '0;
      r_tag <= '0;
    end else if (w_en) begin
      r_vld <= (r_vld << 1) | LAT'(w_issue);
      r_tag <= (r_tag << 1) | LAT'(w_grant);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_sel        <= 1'b0;
    end else if (w_issue) begin
      r_last_grant <= w_grant;
      r_a          <= w_a;
      r_b          <= w_b;
      r_sel        <= w_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_rsp_hs})
        2'b10:   r_inflight <= r_inflight + CntW'(1);
        2'b01:   r_inflight <= r_inflight - CntW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_arbiter.sv
// Scoreboard bench for mul_div_arbiter with a table-driven stand-in for the shared
// multiply/divide pipeline.
module tb_mul_div_arbiter;
  localparam int unsigned LAT = 3;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  mul_div_arbiter_if #(.LAT(LAT)) bus ();
  mul_div_arbiter #(.LAT(LAT)) dut (.i_clk(clk), .i_arst(arst), .bus(bus));

  typedef struct packed {
    logic        client;
    logic [31:0] r;
    logic [4:0]  f;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cur0 = 0;
  int          cur1 = 0;
  logic [31:0] va[NV];
  logic [31:0] vb[NV];
  logic        vs[NV];
  logic [31:0] vr[NV];
  logic [4:0]  vf[NV];

  // Hand-computed single-precision vectors: {a, b, sel} -> {r, flags}.
  initial begin
    va[0] = 32'h40000000; vb[0] = 32'h40400000; vs[0] = 0; vr[0] = 32'h40C00000; vf[0] = 5'h00;
    va[1] = 32'h3F800000; vb[1] = 32'h3F800000; vs[1] = 0; vr[1] = 32'h3F800000; vf[1] = 5'h00;
    va[2] = 32'h40C00000; vb[2] = 32'h40000000; vs[2] = 1; vr[2] = 32'h40400000; vf[2] = 5'h00;
    va[3] = 32'h3F800000; vb[3] = 32'h00000000; vs[3] = 1; vr[3] = 32'h7F800000; vf[3] = 5'h08;
    va[4] = 32'h3F800000; vb[4] = 32'h40400000; vs[4] = 1; vr[4] = 32'h3EAAAAAB; vf[4] = 5'h01;
    va[5] = 32'h40800000; vb[5] = 32'h3F000000; vs[5] = 0; vr[5] = 32'h40000000; vf[5] = 5'h00;
    va[6] = 32'h40000000; vb[6] = 32'h40000000; vs[6] = 0; vr[6] = 32'h40800000; vf[6] = 5'h00;
    va[7] = 32'h3FC00000; vb[7] = 32'h40000000; vs[7] = 0; vr[7] = 32'h40400000; vf[7] = 5'h00;
    va[8] = 32'h00000000; vb[8] = 32'h00000000; vs[8] = 1; vr[8] = 32'h7FC00000; vf[8] = 5'h10;
    va[9] = 32'h41000000; vb[9] = 32'h40000000; vs[9] = 1; vr[9] = 32'h40800000; vf[9] = 5'h00;
  end

  function automatic logic [36:0] lookup(input logic [31:0] a, input logic [31:0] b,
                                         input logic sel);
    for (int i = 0; i < NV; i++) begin
      if (va[i] == a && vb[i] == b && vs[i] == sel) return {vf[i], vr[i]};
    end
    return {5'h1F, 32'hDEADBEEF};
  endfunction

  // Stand-in for the shared unit: LAT stages advancing on mdu_en.
  logic [31:0] m_r[LAT];
  logic [4:0]  m_f[LAT];
  logic [36:0] m_in;
  assign m_in = lookup(bus.mdu_a, bus.mdu_b, bus.mdu_sel);
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < LAT; i++) begin
        m_r[i] <= '0;
        m_f[i] <= '0;
      end
    end else if (bus.mdu_en) begin
      m_r[0] <= m_in[31:0];
      m_f[0] <= m_in[36:32];
      for (int i = 1; i < LAT; i++) begin
        m_r[i] <= m_r[i-1];
        m_f[i] <= m_f[i-1];
      end
    end
  end
  assign bus.mdu_r     = m_r[LAT-1];
  assign bus.mdu_flags = m_f[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Accept tracker: every accepted request pushes its expected result.
  always @(negedge clk) begin
    if (arst) begin
      if (bus.req_ready == 2'b11) check("req_ready_onehot", 32'(bus.req_ready), 32'h1);
      if (bus.req_valid[0] && bus.req_ready[0]) sb_q.push_back({1'b0, vr[cur0], vf[cur0]});
      if (bus.req_valid[1] && bus.req_ready[1]) sb_q.push_back({1'b1, vr[cur1], vf[cur1]});
    end
  end

  // Response monitor: pop and compare on each response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (arst) begin
      if (bus.rsp_valid != 2'b00) check("rsp_onehot", 32'($countones(bus.rsp_valid)), 32'h1);
      for (int i = 0; i < 2; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", 32'(i), 32'hFFFFFFFF);
          end else begin
            e = sb_q.pop_front();
            check("rsp_client", 32'(i), 32'(e.client));
            check("rsp_r", bus.rsp_r, e.r);
            check("rsp_flags", 32'(bus.rsp_flags), 32'(e.f));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input int i0, input int i1);
    cur0 = i0;
    cur1 = i1;
    bus.req_valid = v;
    bus.req_a0    = va[i0];
    bus.req_b0    = vb[i0];
    bus.req_a1    = va[i1];
    bus.req_b1    = vb[i1];
    bus.req_sel   = {vs[i1], vs[i0]};
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (bus.inflight != 0 && n < 50) begin
      step();
      n++;
    end
    check(name, 32'(bus.inflight), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int mx;
    int t3[4] = '{7, 8, 9, 1};
    int c0v[4] = '{1, 2, 3, 0};
    int c1v[4] = '{4, 5, 6, 0};
    int p0;
    int p1;
    drive(2'b00, 0, 0);
    bus.rsp_ready = 2'b11;
    repeat (2) step();
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_inflight", 32'(bus.inflight), 32'h0);
    check("rst_mdu_en", 32'(bus.mdu_en), 32'h1);
    check("rst_mdu_a", bus.mdu_a, 32'h0);
    check("rst_mdu_sel", 32'(bus.mdu_sel), 32'h0);
    arst = 1'b1;

    // Single op from client 0 while idle.
    drive(2'b01, 0, 0);
    #1 check("t1_ready", 32'(bus.req_ready), 32'h1);
    step();
    drive(2'b00, 0, 0);
    check("t1_inflight1", 32'(bus.inflight), 32'h1);
    n = 1;
    while (!bus.rsp_valid[0] && n < 10) begin
      step();
      n++;
    end
    check("t1_latency", 32'(n), 32'(LAT));
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    step();
    check("t1_inflight0", 32'(bus.inflight), 32'h0);

    // Only client 1 for four cycles.
    mx = 0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b10, 0, t3[k]);
      #1 check("t3_ready", 32'(bus.req_ready), 32'h2);
      step();
      if (int'(bus.inflight) > mx) mx = int'(bus.inflight);
    end
    drive(2'b00, 0, 0);
    check("t3_inflight_max", 32'(mx), 32'h3);
    wait_drain("t3_drain");

    // Both clients valid: last grant was client 1, so client 0 leads.
    p0 = 0;
    p1 = 0;
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, c0v[p0], c1v[p1]);
      #1 check("t2_grant", 32'(bus.req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
      step();
      if (k % 2 == 1) p1++;
      else p0++;
    end
    drive(2'b00, 0, 0);
    wait_drain("t2_drain");

    // Backpressure on client 0 with three ops in flight.
    bus.rsp_ready = 2'b10;
    drive(2'b01, 0, 0);
    step();
    drive(2'b10, 0, 2);
    step();
    drive(2'b01, 3, 0);
    step();
    drive(2'b11, 4, 5);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_mdu_en", 32'(bus.mdu_en), 32'h0);
      check("t4_req_ready", 32'(bus.req_ready), 32'h0);
      check("t4_rsp_r", bus.rsp_r, 32'h40C00000);
      check("t4_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("t4_inflight", 32'(bus.inflight), 32'h3);
      step();
    end
    drive(2'b00, 0, 0);
    bus.rsp_ready = 2'b11;
    wait_drain("t4_drain");

    // Empty tail ignores rsp_ready.
    bus.rsp_ready = 2'b00;
    drive(2'b01, 4, 0);
    #1;
    check("t5_mdu_en", 32'(bus.mdu_en), 32'h1);
    check("t5_ready", 32'(bus.req_ready), 32'h1);
    step();
    drive(2'b00, 0, 0);
    check("t5_inflight", 32'(bus.inflight), 32'h1);
    repeat (LAT - 1) step();
    check("t5_stall_valid", 32'(bus.rsp_valid), 32'h1);
    check("t5_stall_en", 32'(bus.mdu_en), 32'h0);
    bus.rsp_ready = 2'b11;
    wait_drain("t5_drain");

    // Reset with two ops in flight.
    drive(2'b01, 5, 0);
    step();
    drive(2'b10, 0, 6);
    step();
    drive(2'b00, 0, 0);
    arst = 1'b0;
    sb_q.delete();
    step();
    arst = 1'b1;
    check("t6_inflight", 32'(bus.inflight), 32'h0);
    for (int k = 0; k < LAT + 1; k++) begin
      check("t6_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      step();
    end
    drive(2'b11, 7, 8);
    #1 check("t6_first_grant", 32'(bus.req_ready), 32'h1);
    step();
    drive(2'b10, 7, 8);
    step();
    drive(2'b00, 0, 0);
    wait_drain("t6_drain");

    step();
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
